// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_t;

    localparam int LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one data memory between IF and D ports
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      cancels delivery of an in-flight IF read
//   if_req/if_addr             IF read request (held until if_valid)
//   if_rdata/if_valid/if_stall IF read data (zero-extended), completion pulse, stall
//   d_req/d_wr/d_addr/d_wdata  D request (held stable until d_valid)
//   d_rdata/d_valid/d_stall    D read data (zero-extended, 0 for writes), completion pulse, stall
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata  single-port memory interface
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter only needs to hold LAT-1; keep at least one bit for LAT=1.
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    arb_state_t    state;
    arb_gnt_t      gnt;
    arb_gnt_t      last_gnt;
    arb_gnt_t      pick;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic          flushed;

    // Only the low DW bits of the write data reach the memory.
    logic          unused_wdata_hi;
    assign unused_wdata_hi = ^d_wdata[31:DW];

    // Round-robin pick: on contention the port that was not served last wins,
    // so with last_gnt reset to IF the first contention goes to D.
    always_comb begin
        pick = GNT_IF;
        if (if_req && d_req) begin
            pick = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
        end else if (d_req) begin
            pick = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= GNT_IF;
            last_gnt <= GNT_IF;
            cnt      <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            flushed  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        // Latch the request so later changes by the requester
                        // cannot disturb the memory controls mid-access.
                        gnt      <= pick;
                        last_gnt <= pick;
                        addr_q   <= (pick == GNT_D) ? d_addr : if_addr;
                        wr_q     <= (pick == GNT_D) && d_wr;
                        wdata_q  <= (pick == GNT_D) ? d_wdata[DW-1:0] : '0;
                        cnt      <= CW'(LAT - 1);
                        flushed  <= 1'b0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (flush && (gnt == GNT_IF)) begin
                        flushed <= 1'b1;
                    end
                    if (cnt == '0) begin
                        // Read data still lands in if_rdata after a flush;
                        // only the valid pulse is withheld.
                        if (gnt == GNT_IF) begin
                            if_rdata <= 32'(mem_rdata);
                        end else begin
                            d_rdata <= wr_q ? 32'd0 : 32'(mem_rdata);
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // A flush seen here would be cleared by the same edge
                    // that returns to IDLE, so flushed simply clears.
                    flushed <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_wr    = (state == ACCESS) && wr_q && (gnt == GNT_D);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = (state == DONE) && (gnt == GNT_IF) && !flushed;
    assign d_valid   = (state == DONE) && (gnt == GNT_D);

    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int HIST = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [31:0]   if_rdata;
    logic          if_valid, if_stall;
    logic          d_req = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_valid, d_stall;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          d1_req = 1'b0;
    logic [AW-1:0] d1_addr = '0;
    logic [31:0]   d1_rdata;
    logic          d1_valid, mem1_en;
    logic [AW-1:0] mem1_addr;
    logic [DW-1:0] mem1_rdata;
    logic [31:0]   unused_if1_rdata;
    logic          unused_if1_valid, unused_if1_stall, unused_d1_stall, unused_mem1_wr;
    logic [DW-1:0] unused_mem1_wdata;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] ram  [0:(1<<AW)-1];
    logic [DW-1:0] ram1 [0:(1<<AW)-1];
    int            en_run = 0;
    int            en_run1 = 0;

    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    bit h_if [0:HIST-1];
    bit h_d  [0:HIST-1];

    mem_port_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.LAT(1), .AW(AW), .DW(DW)) dut1 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .if_req(1'b0), .if_addr(16'h0000), .if_rdata(unused_if1_rdata), .if_valid(unused_if1_valid),
        .if_stall(unused_if1_stall),
        .d_req(d1_req), .d_wr(1'b0), .d_addr(d1_addr), .d_wdata(32'h0),
        .d_rdata(d1_rdata), .d_valid(d1_valid), .d_stall(unused_d1_stall),
        .mem_en(mem1_en), .mem_wr(unused_mem1_wr), .mem_addr(mem1_addr), .mem_wdata(unused_mem1_wdata),
        .mem_rdata(mem1_rdata)
    );

    // Memories only present good data on the LAT-th consecutive enabled cycle.
    always @(posedge clk) begin
        if (mem_en && mem_wr) ram[mem_addr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        if (pre_we) ram1[pre_addr] <= pre_data;
        en_run  <= mem_en  ? en_run + 1  : 0;
        en_run1 <= mem1_en ? en_run1 + 1 : 0;
    end
    assign mem_rdata  = (mem_en && en_run == LAT - 1) ? ram[mem_addr] : 16'hDEAD;
    assign mem1_rdata = (mem1_en && en_run1 == 0) ? ram1[mem1_addr] : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; if_req = 1'b0; d_req = 1'b0; d1_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_access(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                             output int lat, output int en_cyc, output int wr_cyc,
                             output logic [DW-1:0] seen_wdata, output logic [31:0] rdata);
        lat = -1; en_cyc = 0; wr_cyc = 0; seen_wdata = '0; rdata = '0;
        if (is_d) begin d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd; end
        else begin if_req = 1'b1; if_addr = a; end
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (mem_en) en_cyc++;
            if (mem_wr) begin wr_cyc++; seen_wdata = mem_wdata; end
            if (is_d ? d_valid : if_valid) begin
                lat = k;
                rdata = is_d ? d_rdata : if_rdata;
            end
        end
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({if_valid, d_valid, mem_en, mem_wr} !== 4'b0) begin errors++;
            $display("FAIL reset_ctrl got %b want 0000", {if_valid, d_valid, mem_en, mem_wr}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, d_rdata); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++;
            $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (d1_valid !== 1'b0 || mem1_en !== 1'b0) begin errors++;
            $display("FAIL reset_lat1 got %b%b want 00", d1_valid, mem1_en); end
        d_req = 1'b1;
        #1;
        checks++; if (d_stall !== 1'b1 || if_stall !== 1'b0) begin errors++;
            $display("FAIL stall_comb got %b%b want 10", d_stall, if_stall); end
        d_req = 1'b0;
        #1;
    endtask

    task automatic test_if_read();
        preload(16'h0010, 16'hBEEF);
        if_req = 1'b1; if_addr = 16'h0010;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            checks++; if (mem_en !== (k <= LAT)) begin errors++;
                $display("FAIL if_mem_en cyc %0d got %b want %b", k, mem_en, k <= LAT); end
            checks++; if (if_valid !== (k == LAT + 1)) begin errors++;
                $display("FAIL if_valid cyc %0d got %b want %b", k, if_valid, k == LAT + 1); end
            checks++; if (if_stall !== (k <= LAT)) begin errors++;
                $display("FAIL if_stall cyc %0d got %b want %b", k, if_stall, k <= LAT); end
            if (k <= LAT) begin
                checks++; if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin errors++;
                    $display("FAIL if_mem_addr got %h wr %b want 0010 0", mem_addr, mem_wr); end
            end
        end
        checks++; if (if_rdata !== 32'h0000BEEF) begin errors++;
            $display("FAIL if_rdata got %h want 0000beef", if_rdata); end
        if_req = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h0000BEEF) begin errors++;
            $display("FAIL if_hold got %b %h want 0 0000beef", if_valid, if_rdata); end
    endtask

    task automatic test_d_write_read();
        int lat, en_c, wr_c;
        logic [DW-1:0] sw;
        logic [31:0] rd;
        do_access(1'b1, 1'b1, 16'h0020, 32'h1234ABCD, lat, en_c, wr_c, sw, rd);
        checks++; if (wr_c != LAT || sw !== 16'hABCD) begin errors++;
            $display("FAIL d_write_strobe got %0d cyc %h want %0d abcd", wr_c, sw, LAT); end
        checks++; if (lat != LAT + 1 || rd !== 32'h0) begin errors++;
            $display("FAIL d_write_done got lat %0d rdata %h want %0d 0", lat, rd, LAT + 1); end
        do_access(1'b1, 1'b0, 16'h0020, 32'h0, lat, en_c, wr_c, sw, rd);
        checks++; if (rd !== 32'h0000ABCD || wr_c != 0 || en_c != LAT) begin errors++;
            $display("FAIL d_read_back got %h wr %0d en %0d want 0000abcd 0 %0d", rd, wr_c, en_c, LAT); end
    endtask

    task automatic test_contention();
        int order[$];
        int exp_order[4] = '{1, 0, 1, 0};
        int left_if, left_d;
        bit rr_if, rr_d;
        do_reset();
        preload(16'h0030, 16'h1111);
        preload(16'h0031, 16'h2222);
        if_req = 1'b1; if_addr = 16'h0030;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0031;
        left_if = 2; left_d = 2; rr_if = 0; rr_d = 0;
        for (int k = 1; k <= 40 && (left_if + left_d) > 0; k++) begin
            tick();
            if (rr_if) begin if_req = 1'b1; rr_if = 0; end
            if (rr_d) begin d_req = 1'b1; rr_d = 0; end
            if (if_valid || d_valid) begin
                checks++; if (k != order.size() * (LAT + 2) + LAT + 1) begin errors++;
                    $display("FAIL cont_timing got cyc %0d want %0d", k, order.size() * (LAT + 2) + LAT + 1); end
            end
            if (if_valid) begin
                order.push_back(0);
                checks++; if (if_rdata !== 32'h1111) begin errors++;
                    $display("FAIL cont_if_data got %h want 00001111", if_rdata); end
                left_if--; if_req = 1'b0; rr_if = (left_if > 0);
            end
            if (d_valid) begin
                order.push_back(1);
                checks++; if (d_rdata !== 32'h2222) begin errors++;
                    $display("FAIL cont_d_data got %h want 00002222", d_rdata); end
                left_d--; d_req = 1'b0; rr_d = (left_d > 0);
            end
        end
        checks++; if (order.size() != 4) begin errors++;
            $display("FAIL cont_count got %0d want 4", order.size()); end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++;
                $display("FAIL cont_order[%0d] got %0d want %0d", i, order[i], exp_order[i]); end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_flush();
        int if_first, d_first;
        preload(16'h0040, 16'h5555);
        preload(16'h0041, 16'h6666);
        if_first = -1; d_first = -1;
        if_req = 1'b1; if_addr = 16'h0040;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0041; end
            flush = (k == 2);
            if (k == LAT + 1) begin
                checks++; if (if_rdata !== 32'h5555 || mem_en !== 1'b0) begin errors++;
                    $display("FAIL flush_rdata got %h en %b want 00005555 0", if_rdata, mem_en); end
            end
            if (if_valid && if_first < 0) begin if_first = k; if_req = 1'b0; end
            if (d_valid) begin
                d_first = k; d_req = 1'b0;
                checks++; if (d_rdata !== 32'h6666) begin errors++;
                    $display("FAIL flush_d_data got %h want 00006666", d_rdata); end
            end
        end
        checks++; if (d_first != 2 * LAT + 3) begin errors++;
            $display("FAIL flush_d_next got cyc %0d want %0d", d_first, 2 * LAT + 3); end
        checks++; if (if_first != 3 * LAT + 5) begin errors++;
            $display("FAIL flush_if_suppress got cyc %0d want %0d", if_first, 3 * LAT + 5); end
        if_req = 1'b0; d_req = 1'b0; flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int lat, en_c, wr_c;
        logic [DW-1:0] sw;
        logic [31:0] rd;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0050; d_wdata = 32'hFFFF7777;
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_en !== 1'b1) begin errors++;
            $display("FAIL rmw_started got %b%b want 11", mem_en, mem_wr); end
        rst = 1'b1;
        tick();
        rst = 1'b0; d_req = 1'b0;
        checks++; if ({mem_en, mem_wr, d_valid} !== 3'b000) begin errors++;
            $display("FAIL rmw_abort got %b want 000", {mem_en, mem_wr, d_valid}); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || d_rdata !== 32'h0) begin errors++;
            $display("FAIL rmw_regs got %h %h %h want 0 0 0", mem_addr, mem_wdata, d_rdata); end
        do_access(1'b1, 1'b1, 16'h0050, 32'hFFFF7777, lat, en_c, wr_c, sw, rd);
        checks++; if (lat != LAT + 1 || wr_c != LAT || sw !== 16'h7777) begin errors++;
            $display("FAIL rmw_reissue got lat %0d wr %0d data %h want %0d %0d 7777", lat, wr_c, sw, LAT + 1, LAT); end
        do_access(1'b1, 1'b0, 16'h0050, 32'h0, lat, en_c, wr_c, sw, rd);
        checks++; if (rd !== 32'h00007777) begin errors++;
            $display("FAIL rmw_readback got %h want 00007777", rd); end
    endtask

    task automatic test_random();
        logic [15:0] ref_mem [0:15];
        bit pend_if, pend_d, stop, w_d;
        logic [3:0] a_if, a_d;
        logic [31:0] wd_d, exp_ifr, exp_dr;
        logic [15:0] v;
        int wait_if, wait_d, last_srv, g, exp_w, n_done;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            ref_mem[i] = v;
            preload(16'h0100 + 16'(i), v);
        end
        pend_if = 0; pend_d = 0; stop = 0; w_d = 0; a_if = '0; a_d = '0; wd_d = '0;
        exp_ifr = '0; exp_dr = '0; wait_if = 0; wait_d = 0; last_srv = 0; n_done = 0;
        for (int k = 0; k < 600 && !stop; k++) begin
            g = (tick_n - (LAT + 1)) % HIST;
            if (if_valid && d_valid) begin
                checks++; errors++;
                $display("FAIL rnd_both_valid got 11 want one-hot");
            end
            if (if_valid) begin
                exp_w = (h_if[g] && h_d[g]) ? 1 - last_srv : (h_d[g] ? 1 : 0);
                checks++; if (exp_w != 0) begin errors++;
                    $display("FAIL rnd_rr got IF want %0d at cyc %0d", exp_w, tick_n); end
                exp_ifr = {16'h0, ref_mem[a_if]};
                checks++; if (if_rdata !== exp_ifr) begin errors++;
                    $display("FAIL rnd_if_data got %h want %h", if_rdata, exp_ifr); end
                checks++; if (d_rdata !== exp_dr) begin errors++;
                    $display("FAIL rnd_d_hold got %h want %h", d_rdata, exp_dr); end
                last_srv = 0; pend_if = 0; if_req = 1'b0; n_done++;
            end
            if (d_valid) begin
                exp_w = (h_if[g] && h_d[g]) ? 1 - last_srv : (h_d[g] ? 1 : 0);
                checks++; if (exp_w != 1) begin errors++;
                    $display("FAIL rnd_rr got D want %0d at cyc %0d", exp_w, tick_n); end
                if (w_d) ref_mem[a_d] = wd_d[15:0];
                exp_dr = w_d ? 32'h0 : {16'h0, ref_mem[a_d]};
                checks++; if (d_rdata !== exp_dr) begin errors++;
                    $display("FAIL rnd_d_data got %h want %h", d_rdata, exp_dr); end
                checks++; if (if_rdata !== exp_ifr) begin errors++;
                    $display("FAIL rnd_if_hold got %h want %h", if_rdata, exp_ifr); end
                last_srv = 1; pend_d = 0; d_req = 1'b0; n_done++;
            end
            if (pend_if) wait_if++;
            if (pend_d) wait_d++;
            if (wait_if > 3 * (LAT + 2) || wait_d > 3 * (LAT + 2)) begin
                checks++; errors++; stop = 1;
                $display("FAIL rnd_timeout got wait %0d/%0d want <= %0d", wait_if, wait_d, 3 * (LAT + 2));
            end
            if (!pend_if && $urandom_range(0, 2) == 0) begin
                pend_if = 1; wait_if = 0; a_if = 4'($urandom);
                if_req = 1'b1; if_addr = 16'h0100 + 16'(a_if);
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1; wait_d = 0; a_d = 4'($urandom); w_d = 1'($urandom); wd_d = $urandom;
                d_req = 1'b1; d_wr = w_d; d_addr = 16'h0100 + 16'(a_d); d_wdata = wd_d;
            end
            h_if[tick_n % HIST] = if_req;
            h_d[tick_n % HIST]  = d_req;
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < LAT + 3; k++) tick();
        checks++; if (n_done < 40) begin errors++;
            $display("FAIL rnd_progress got %0d want >= 40", n_done); end
    endtask

    task automatic test_lat1_back_to_back();
        int nvalid;
        int exp_cyc[2] = '{2, 5};
        logic [31:0] exp_dat[2] = '{32'h0000A1A1, 32'h0000B2B2};
        preload(16'h0001, 16'hA1A1);
        preload(16'h0002, 16'hB2B2);
        nvalid = 0;
        d1_req = 1'b1; d1_addr = 16'h0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (d1_valid) begin
                if (nvalid < 2) begin
                    checks++; if (k != exp_cyc[nvalid] || d1_rdata !== exp_dat[nvalid]) begin errors++;
                        $display("FAIL lat1_read%0d got cyc %0d %h want %0d %h", nvalid, k, d1_rdata,
                                 exp_cyc[nvalid], exp_dat[nvalid]); end
                end
                nvalid++;
                if (nvalid == 1) d1_addr = 16'h0002;
                else d1_req = 1'b0;
            end
        end
        checks++; if (nvalid != 2) begin errors++;
            $display("FAIL lat1_count got %0d want 2", nvalid); end
        d1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_d_write_read();
        test_contention();
        test_flush();
        test_reset_mid_write();
        test_random();
        test_lat1_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data memory (16-bit address, 16-bit data) between the fetch stage's read-only port (IF) and the memory stage's read/write port (D). It grants one requester at a time and holds the memory controls stable for LAT cycles. It returns zero-extended 32-bit read data and drives stall back to each pipeline stage. A pipeline flush suppresses delivery of an in-flight instruction read.

Parameters:
LAT, 2, memory access latency in cycles; legal range is 1 or greater; mem_rdata is valid on the LAT-th access cycle.
AW, 16, address width.
DW, 16, memory data width; read data is zero-extended to 32 bits.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; cancels delivery of an in-flight IF read
if_req  in  1  IF read request; held until if_valid
if_addr  in  AW  IF read address
if_rdata  out  32  IF read data, registered
if_valid  out  1  one-cycle pulse: if_rdata updated
if_stall  out  1  IF must stall
d_req  in  1  D request; held, with d_wr/d_addr/d_wdata stable, until d_valid
d_wr  in  1  1 = write, 0 = read
d_addr  in  AW  D address
d_wdata  in  32  write data; only [DW-1:0] is stored
d_rdata  out  32  D read data, registered
d_valid  out  1  one-cycle pulse: D access complete
d_stall  out  1  D must stall
mem_en  out  1  memory enable
mem_wr  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- States are IDLE, ACCESS and DONE.
- Reset values: state=IDLE, cnt=0, last_gnt=IF, flushed=0.
- Reset values of outputs: if_valid, d_valid, mem_en and mem_wr are 0; if_rdata, d_rdata, mem_addr and mem_wdata are 0.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requesting: grant the port not in last_gnt (round-robin). The first contention after reset therefore goes to D.
- On grant: latch the request into gnt, addr, wr and wdata; set last_gnt=gnt; cnt=LAT-1; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr and mem_wdata come from the latched values.
  - mem_wr = wr and (gnt==D), asserted for every ACCESS cycle.
  - Each cycle with cnt==0: sample mem_rdata, zero-extended, into the granted port's rdata register and go to DONE; otherwise decrement cnt.
  - D writes load d_rdata with 0.
- DONE:
  - Pulse the granted port's valid for one cycle; mem_en=0; go to IDLE.
  - The requester drops or changes its req in this same cycle. IDLE re-evaluates requests on the following cycle, so a held req is never double-served.
- Latency: request seen in IDLE to valid = LAT+1 cycles. Throughput is one access per LAT+2 cycles.
- Stall (combinational):
  - if_stall = if_req and not if_valid.
  - d_stall = d_req and not d_valid.
- Flush:
  - flush=1 while gnt==IF in ACCESS or DONE sets flushed. The memory read still completes, and if_rdata is still updated.
  - if_valid is suppressed while flushed is set. flushed clears on the transition to IDLE.
  - flush has no effect on D accesses or in IDLE.
- rdata registers hold their value between completions. Each port's register is updated only by its own accesses.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values. An in-progress write is abandoned (mem_wr drops); memory contents are not repaired.
- An address or data change by the granted requester during ACCESS is ignored, because the latched copy is used.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - grant enum {GNT_IF, GNT_D}
  - LAT_DEFAULT=2
- No sub-module. The round-robin pick and the latency counter live in a single FSM module of roughly 150 lines.

Test Plan:
1. LAT=2, single IF read: if_req=1, if_addr=0x0010, memory holds 0xBEEF at 0x0010 -> mem_en high for 2 cycles; if_valid pulses 3 cycles after request; if_rdata=0x0000BEEF; if_stall high until the pulse.
2. D write then read: write d_addr=0x0020, d_wdata=0x1234ABCD -> mem_wr high for exactly 2 cycles with mem_wdata=0xABCD; d_valid pulse; d_rdata=0. Then read 0x0020 -> d_rdata=0x0000ABCD.
3. Contention after reset: if_req and d_req both asserted at cycle 0 and held -> D served first, then IF. Both re-raise -> order is D, IF, D, IF; neither port waits more than one access.
4. Flush: IF read in flight, flush pulse in the second ACCESS cycle -> if_valid never pulses and the arbiter returns to IDLE. A D request pending behind it is granted next.
5. Reset mid-write: rst asserted in the first ACCESS cycle of a D write -> the next cycle has state=IDLE, mem_wr=0, d_valid=0. Re-issuing the write completes normally.
6. LAT=1 build: back-to-back D reads at addresses 0x0001 and 0x0002 -> each d_valid arrives 2 cycles after its grant, with correct zero-extended data and no double service.
